// File: rtl/mesh_router_input_buffer.sv
// Per-port ingress FIFOs with a round-robin picker that holds one packet until the router grants it.
// Optional macro ROUTER_IN_STATS_EN adds per-port saturating drop counters on output drop_count.
package packet_pkg;
  typedef struct packed {
    logic [7:0]  dest;
    logic [7:0]  src;
    logic [15:0] payload;
  } packet_t;
endpackage

module mesh_router_input_buffer
  import packet_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NPORT = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  packet_t                      in_data   [NPORT],
  input  logic [NPORT-1:0]             in_valid,
  output logic [NPORT-1:0]             in_ready,
  output packet_t                      out_data  [NPORT],
  output logic [NPORT-1:0]             out_valid,
  input  logic                         grant,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy [NPORT]
`ifdef ROUTER_IN_STATS_EN
  ,
  output logic [15:0]                  drop_count [NPORT]
`endif
);

  localparam int OW   = $clog2(DEPTH + 1);
  localparam int PTRW = $clog2(DEPTH);
  localparam int IW   = $clog2(NPORT);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     cur_q, cur_d;
  logic [IW-1:0]     last_q, last_d;
  packet_t           hold_q, hold_d;
  logic [IW-1:0]     pick_idx;
  logic              pick_found;
  logic [NPORT-1:0]  wr_en;
  logic [NPORT-1:0]  pop;
  logic [NPORT-1:0]  nonempty;
  packet_t           head [NPORT];

  function automatic logic [IW-1:0] wrap_port(input int v);
    return IW'(v % NPORT);
  endfunction

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic            rdy_q, rdy_d;
    packet_t         mem [DEPTH];

    // Write acceptance depends only on registered fullness, so a same-cycle pop never frees a slot.
    assign wr_en[gi] = in_valid[gi] & rdy_q;
    assign pop[gi]   = (state_q == HOLD) && grant && (cur_q == IW'(gi));

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (wr_en[gi]) wr_ptr_d = wr_ptr_q + PTRW'(1);
      if (pop[gi])   rd_ptr_d = rd_ptr_q + PTRW'(1);
      case ({wr_en[gi], pop[gi]})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
      rdy_d = (occ_d != OW'(DEPTH));
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        occ_q    <= '0;
        rdy_q    <= 1'b1;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        occ_q    <= occ_d;
        rdy_q    <= rdy_d;
      end
    end

    always_ff @(posedge clk) begin
      if (rst && wr_en[gi]) mem[wr_ptr_q] <= in_data[gi];
    end

    assign head[gi]      = mem[rd_ptr_q];
    assign nonempty[gi]  = (occ_q != '0);
    assign occupancy[gi] = occ_q;
    assign in_ready[gi]  = rdy_q;
    assign out_valid[gi] = (state_q == HOLD) && (cur_q == IW'(gi));
    assign out_data[gi]  = hold_q;

`ifdef ROUTER_IN_STATS_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
      drop_d = drop_q;
      if (in_valid[gi] && !rdy_q && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk) begin
      if (!rst) drop_q <= '0;
      else      drop_q <= drop_d;
    end

    assign drop_count[gi] = drop_q;
`endif
  end

  // Scan backwards so the last hit is the first non-empty port after last_q.
  always_comb begin
    pick_found = |nonempty;
    pick_idx   = '0;
    for (int k = NPORT; k >= 1; k--) begin
      if (nonempty[wrap_port(int'(last_q) + k)]) pick_idx = wrap_port(int'(last_q) + k);
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = HOLD;
          cur_d   = pick_idx;
          hold_d  = head[pick_idx];
        end
      end
      HOLD: begin
        if (grant) begin
          state_d = IDLE;
          last_d  = cur_q;
          hold_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      last_q  <= IW'(NPORT - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

endmodule
